// File: rtl/input_checker_pkg.sv
// Shared definitions for the tile-memory game: tile width, default buffer depth
// and input timeout, FSM state encoding, and key-event decode helpers.
package input_checker_pkg;

    localparam int TILE_W             = 2;
    localparam int IDX_W              = 5;
    localparam int TMR_W              = 28;
    localparam int MAX_LEN_DEF        = 16;
    localparam int TIMEOUT_CYCLES_DEF = 250_000_000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_PASS  = 3'd3;
    localparam logic [2:0] ST_FAIL  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_WAIT  = ST_WAIT,
        S_CHECK = ST_CHECK,
        S_PASS  = ST_PASS,
        S_FAIL  = ST_FAIL
    } state_t;

    function automatic logic [TILE_W-1:0] event_tile(input logic [3:0] ev);
        logic [TILE_W-1:0] t;
        t = '0;
        if (ev[3])      t = 2'd3;
        else if (ev[2]) t = 2'd2;
        else if (ev[1]) t = 2'd1;
        return t;
    endfunction

    function automatic logic [2:0] event_count(input logic [3:0] ev);
        return 3'(ev[0]) + 3'(ev[1]) + 3'(ev[2]) + 3'(ev[3]);
    endfunction

endpackage

// File: rtl/input_checker_key_edge_sync.sv
// Two-flop synchronizer for the four active-low tile keys plus press detection:
// a press is a 1->0 transition of the synchronized level, so a held key fires once.
module key_edge_sync (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] keys,
    output logic [3:0] key_event
);

    logic [3:0] meta;
    logic [3:0] sync;
    logic [3:0] prev;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= '1;
            sync <= '1;
            prev <= '1;
        end else begin
            meta <= keys;
            sync <= meta;
            prev <= sync;
        end
    end

    assign key_event = prev & ~sync;

endmodule

// File: rtl/input_checker.sv
// Records the flashed tile sequence, then checks the player's key presses
// against it and reports each press, progress and the round result.
//
// state | meaning
// IDLE  | buffer writable; waits for start
// WAIT  | waits for one key event; counts the idle timeout
// CHECK | press_valid/correct shown; decides next step
// PASS  | round_pass pulse
// FAIL  | round_fail pulse (a bad start spends one extra cycle here first)
module input_checker
    import input_checker_pkg::*;
#(
    parameter int MAX_LEN        = MAX_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              seq_clear,
    input  logic              seq_wr,
    input  logic [TILE_W-1:0] seq_tile,
    input  logic [IDX_W-1:0]  length,
    input  logic              start,
    input  logic [3:0]        keys,
    output logic              busy,
    output logic [IDX_W-1:0]  seq_count,
    output logic              seq_full,
    output logic              press_valid,
    output logic [TILE_W-1:0] press_tile,
    output logic              correct,
    output logic              round_pass,
    output logic              round_fail,
    output logic [IDX_W-1:0]  input_index
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LEN_MAX  = IDX_W'(MAX_LEN);

    state_t              state;
    logic [TILE_W-1:0]   seq_buf [MAX_LEN];
    logic [IDX_W-1:0]    round_len;
    logic [TMR_W-1:0]    timer;
    logic [3:0]          key_event;
    logic [TILE_W-1:0]   expected_tile;
    logic [TILE_W-1:0]   ev_tile;
    logic [2:0]          ev_count;

    key_edge_sync u_key_sync (
        .clock     (clock),
        .resetn    (resetn),
        .keys      (keys),
        .key_event (key_event)
    );

    assign ev_tile  = event_tile(key_event);
    assign ev_count = event_count(key_event);
    assign seq_full = (seq_count == LEN_MAX);

    always_comb begin
        expected_tile = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (input_index == IDX_W'(i)) expected_tile = seq_buf[i];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seq_count <= '0;
            for (int i = 0; i < MAX_LEN; i++) seq_buf[i] <= '0;
        end else if (state == S_IDLE) begin
            if (seq_clear) begin
                seq_count <= '0;
            end else if (seq_wr && !seq_full) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (seq_count == IDX_W'(i)) seq_buf[i] <= seq_tile;
                end
                seq_count <= seq_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            input_index <= '0;
            round_len   <= '0;
            timer       <= '0;
            press_valid <= 1'b0;
            press_tile  <= '0;
            correct     <= 1'b0;
            round_pass  <= 1'b0;
            round_fail  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length == '0 || length > seq_count) begin
                            state <= S_FAIL;
                        end else begin
                            input_index <= '0;
                            timer       <= '0;
                            round_len   <= length;
                            state       <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (ev_count >= 3'd2) begin
                        round_fail <= 1'b1;
                        state      <= S_FAIL;
                    end else if (ev_count == 3'd1) begin
                        // Match is resolved here so CHECK can present it as a registered pulse.
                        press_tile  <= ev_tile;
                        press_valid <= 1'b1;
                        correct     <= (ev_tile == expected_tile);
                        state       <= S_CHECK;
                    end else if (timer == TMR_LAST) begin
                        round_fail <= 1'b1;
                        state      <= S_FAIL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_CHECK: begin
                    press_valid <= 1'b0;
                    correct     <= 1'b0;
                    if (!correct) begin
                        round_fail <= 1'b1;
                        state      <= S_FAIL;
                    end else if (input_index + 1'b1 == round_len) begin
                        round_pass <= 1'b1;
                        state      <= S_PASS;
                    end else begin
                        input_index <= input_index + 1'b1;
                        timer       <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_PASS: begin
                    round_pass <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                S_FAIL: begin
                    // Entry from IDLE arrives without the pulse raised yet.
                    if (!round_fail) begin
                        round_fail <= 1'b1;
                    end else begin
                        round_fail <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_checker.sv
// Directed bench for input_checker: round pass, mismatch, timeout, multi-key,
// held key, bad start, buffer limits and asynchronous reset mid-round.
module tb_input_checker;

    logic       clock;
    logic       resetn;
    logic       seq_clear;
    logic       seq_wr;
    logic [1:0] seq_tile;
    logic [4:0] length;
    logic       start;
    logic [3:0] keys;
    logic       busy;
    logic [4:0] seq_count;
    logic       seq_full;
    logic       press_valid;
    logic [1:0] press_tile;
    logic       correct;
    logic       round_pass;
    logic       round_fail;
    logic [4:0] input_index;

    int checks = 0;
    int errors = 0;

    input_checker #(.MAX_LEN(16), .TIMEOUT_CYCLES(20)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .seq_clear   (seq_clear),
        .seq_wr      (seq_wr),
        .seq_tile    (seq_tile),
        .length      (length),
        .start       (start),
        .keys        (keys),
        .busy        (busy),
        .seq_count   (seq_count),
        .seq_full    (seq_full),
        .press_valid (press_valid),
        .press_tile  (press_tile),
        .correct     (correct),
        .round_pass  (round_pass),
        .round_fail  (round_fail),
        .input_index (input_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(seq_count), 32'd0);
        chk({tag, "_full"}, 32'(seq_full), 32'd0);
        chk({tag, "_pv"}, 32'(press_valid), 32'd0);
        chk({tag, "_tile"}, 32'(press_tile), 32'd0);
        chk({tag, "_correct"}, 32'(correct), 32'd0);
        chk({tag, "_pass"}, 32'(round_pass), 32'd0);
        chk({tag, "_fail"}, 32'(round_fail), 32'd0);
        chk({tag, "_index"}, 32'(input_index), 32'd0);
    endtask

    task automatic write_tile(input logic [1:0] t);
        seq_wr   = 1'b1;
        seq_tile = t;
        step(1);
        seq_wr   = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        length = len;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
    endtask

    // Press a key right after an edge; it is first sampled on the next edge k.
    // Returns just after edge k+3 (the cycle after CHECK).
    task automatic press(input logic [1:0] t, input logic exp_ok, input logic [4:0] exp_idx);
        keys = ~(4'b0001 << t);
        step(2);
        chk("pv_early", 32'(press_valid), 32'd0);
        step(1);
        chk("pv", 32'(press_valid), 32'd1);
        chk("correct", 32'(correct), 32'(exp_ok));
        chk("press_tile", 32'(press_tile), 32'(t));
        chk("idx_in_check", 32'(input_index), 32'(exp_idx));
        keys = 4'hF;
        step(1);
        chk("pv_after", 32'(press_valid), 32'd0);
        chk("correct_after", 32'(correct), 32'd0);
    endtask

    initial begin
        int pv_cnt;
        int rf_cnt;
        int rp_cnt;

        resetn    = 1'b0;
        seq_clear = 1'b0;
        seq_wr    = 1'b0;
        seq_tile  = 2'd0;
        length    = 5'd0;
        start     = 1'b0;
        keys      = 4'hF;
        #12;
        chk_all_zero("reset");
        resetn = 1'b1;
        step(2);
        chk_all_zero("post_reset");

        // Round 1: 2,0,3 answered correctly
        write_tile(2'd2);
        chk("count_1", 32'(seq_count), 32'd1);
        write_tile(2'd0);
        write_tile(2'd3);
        chk("count_3", 32'(seq_count), 32'd3);
        do_start(5'd3);
        chk("busy_start", 32'(busy), 32'd1);
        chk("idx_start", 32'(input_index), 32'd0);
        press(2'd2, 1'b1, 5'd0);
        chk("idx_1", 32'(input_index), 32'd1);
        step(6);
        press(2'd0, 1'b1, 5'd1);
        chk("idx_2", 32'(input_index), 32'd2);
        chk("no_pass_yet", 32'(round_pass), 32'd0);
        step(6);
        press(2'd3, 1'b1, 5'd2);
        chk("round_pass", 32'(round_pass), 32'd1);
        chk("busy_in_pass", 32'(busy), 32'd1);
        step(1);
        chk("pass_pulse_end", 32'(round_pass), 32'd0);
        chk("busy_after_pass", 32'(busy), 32'd0);
        chk("tile_holds", 32'(press_tile), 32'd3);

        // Round 2: replay, wrong second press
        chk("count_kept", 32'(seq_count), 32'd3);
        do_start(5'd3);
        press(2'd2, 1'b1, 5'd0);
        step(6);
        press(2'd1, 1'b0, 5'd1);
        chk("mismatch_fail", 32'(round_fail), 32'd1);
        chk("mismatch_pass", 32'(round_pass), 32'd0);
        step(1);
        chk("mismatch_fail_end", 32'(round_fail), 32'd0);
        chk("mismatch_busy", 32'(busy), 32'd0);

        // Timeout: no press, fail after 20 WAIT cycles
        do_start(5'd3);
        chk("to_busy", 32'(busy), 32'd1);
        step(19);
        chk("to_early", 32'(round_fail), 32'd0);
        chk("to_busy_19", 32'(busy), 32'd1);
        step(1);
        chk("to_fail", 32'(round_fail), 32'd1);
        step(1);
        chk("to_fail_end", 32'(round_fail), 32'd0);
        chk("to_busy_end", 32'(busy), 32'd0);

        // Keys 0 and 1 together
        do_start(5'd3);
        keys = 4'b1100;
        step(2);
        chk("multi_early", 32'(round_fail), 32'd0);
        step(1);
        chk("multi_fail", 32'(round_fail), 32'd1);
        chk("multi_pv", 32'(press_valid), 32'd0);
        keys = 4'hF;
        step(1);
        chk("multi_busy", 32'(busy), 32'd0);
        chk("multi_tile", 32'(press_tile), 32'd1);

        // Held key 3 against sequence 3,1,2: one event then timeout
        seq_clear = 1'b1;
        step(1);
        seq_clear = 1'b0;
        chk("clear", 32'(seq_count), 32'd0);
        write_tile(2'd3);
        write_tile(2'd1);
        write_tile(2'd2);
        do_start(5'd3);
        keys   = 4'b0111;
        pv_cnt = 0;
        rf_cnt = 0;
        rp_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (press_valid === 1'b1) pv_cnt++;
            if (round_fail === 1'b1) rf_cnt++;
            if (round_pass === 1'b1) rp_cnt++;
        end
        keys = 4'hF;
        chk("held_pv_count", 32'(pv_cnt), 32'd1);
        chk("held_fail_count", 32'(rf_cnt), 32'd1);
        chk("held_pass_count", 32'(rp_cnt), 32'd0);
        chk("held_busy", 32'(busy), 32'd0);

        // Bad starts
        do_start(5'd4);
        chk("bad_busy", 32'(busy), 32'd1);
        chk("bad_fail_early", 32'(round_fail), 32'd0);
        step(1);
        chk("bad_fail", 32'(round_fail), 32'd1);
        step(1);
        chk("bad_fail_end", 32'(round_fail), 32'd0);
        chk("bad_busy_end", 32'(busy), 32'd0);
        do_start(5'd0);
        step(1);
        chk("zero_len_fail", 32'(round_fail), 32'd1);
        step(1);

        // Buffer limits
        seq_clear = 1'b1;
        seq_wr    = 1'b1;
        step(1);
        seq_clear = 1'b0;
        chk("clear_priority", 32'(seq_count), 32'd0);
        for (int i = 0; i < 17; i++) begin
            seq_tile = 2'(i);
            step(1);
        end
        seq_wr = 1'b0;
        chk("full_count", 32'(seq_count), 32'd16);
        chk("full_flag", 32'(seq_full), 32'd1);
        seq_clear = 1'b1;
        step(1);
        seq_clear = 1'b0;
        chk("empty_full", 32'(seq_full), 32'd0);

        // Writes ignored outside IDLE, then reset mid-round
        write_tile(2'd1);
        do_start(5'd1);
        seq_wr   = 1'b1;
        seq_tile = 2'd2;
        step(1);
        seq_wr   = 1'b0;
        chk("wr_in_wait", 32'(seq_count), 32'd1);
        chk("busy_before_rst", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        #3;
        resetn = 1'b1;
        rf_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (round_fail !== 1'b0) rf_cnt++;
        end
        chk("no_fail_after_rst", 32'(rf_cnt), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
